// File: rtl/square_fixed_point.sv
// Sequential shift-add squarer for unsigned fixed-point operands; one operand bit per cycle, LSB first.
// Optional macro SQUARE_FP_REMAINDER_EN adds a remainder input folded into the result plus an error flag.
module square_fixed_point #(
  parameter int inputWidth    = 8,
  parameter int inputDecWidth = 4
) (
  input  logic                      clk,
  input  logic                      aclr_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [inputWidth-1:0]     q,
`ifdef SQUARE_FP_REMAINDER_EN
  input  logic [inputWidth:0]       remainder,
  output logic                      rem_err,
`endif
  output logic [2*inputWidth-1:0]   radical,
  output logic                      outData_valid
);

  localparam int RW = 2 * inputWidth;
  localparam int CW = (inputWidth > 1) ? $clog2(inputWidth) : 1;

  // The result carries 2*inputDecWidth fractional bits, so the fraction must fit in the operand.
  if (inputDecWidth > inputWidth) begin : g_bad_frac
    $error("inputDecWidth must not exceed inputWidth");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [inputWidth-1:0] op_reg;
  logic [RW-1:0]         acc;
  logic [RW-1:0]         addend;
  logic [RW-1:0]         acc_next;
  logic [CW-1:0]         cnt;
  logic                  last_bit;
`ifdef SQUARE_FP_REMAINDER_EN
  logic [inputWidth:0]   rem_reg;
`endif

  assign in_ready      = (state == IDLE);
  assign outData_valid = (state == DONE);
  assign last_bit      = (cnt == CW'(inputWidth - 1));

  always_comb begin
    addend = '0;
    if (op_reg[cnt]) begin
      addend = {{inputWidth{1'b0}}, op_reg} << cnt;
    end
    acc_next = acc + addend;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final accumulation step writes radical directly, so the result lands on the same edge that enters DONE.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      op_reg  <= '0;
      acc     <= '0;
      cnt     <= '0;
      radical <= '0;
`ifdef SQUARE_FP_REMAINDER_EN
      rem_reg <= '0;
      rem_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_reg <= q;
            acc    <= '0;
            cnt    <= '0;
`ifdef SQUARE_FP_REMAINDER_EN
            rem_reg <= remainder;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
`ifdef SQUARE_FP_REMAINDER_EN
            radical <= acc_next + RW'(rem_reg);
            rem_err <= (rem_reg > {op_reg, 1'b0});
`else
            radical <= acc_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_fixed_point.sv
// Scoreboard bench for square_fixed_point: stimulus pushes expected results, a negedge monitor pops and compares.
// Remainder checks are compiled only when SQUARE_FP_REMAINDER_EN is defined.
module tb_square_fixed_point;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [15:0] radical;
  logic        outData_valid;
`ifdef SQUARE_FP_REMAINDER_EN
  logic [8:0]  remainder;
  logic        rem_err;
`endif

  typedef struct {
    logic [15:0] rad;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  square_fixed_point #(.inputWidth(8), .inputDecWidth(4)) dut (
    .clk           (clk),
    .aclr_n        (aclr_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .q             (q),
`ifdef SQUARE_FP_REMAINDER_EN
    .remainder     (remainder),
    .rem_err       (rem_err),
`endif
    .radical       (radical),
    .outData_valid (outData_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expectation, arrive on time and last one cycle.
  always @(negedge clk) begin
    if (aclr_n && outData_valid) begin
      check_output("pulse_width", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        check_output("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("radical", {16'd0, radical}, {16'd0, e.rad});
        check_output("latency", cyc, e.cyc);
`ifdef SQUARE_FP_REMAINDER_EN
        check_output("rem_err", {31'd0, rem_err}, {31'd0, e.err});
`endif
      end
    end
    prev_valid <= outData_valid;
  end

  // Waits for in_ready, accepts the operand on the next edge and records the expected result.
  task automatic apply_stimulus(input logic [7:0] val, input logic [8:0] rem,
                                input logic [15:0] exp_rad, input logic exp_err,
                                input logic hold, output int acc_cyc);
    int n;
    exp_t e;
    in_valid = 1'b1;
    q        = val;
`ifdef SQUARE_FP_REMAINDER_EN
    remainder = rem;
`endif
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    acc_cyc = 0;
    if (!in_ready) begin
      check_output("accept_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      e.rad = exp_rad;
      e.err = exp_err;
      e.cyc = cyc + 8;
      sb.push_back(e);
      q = 8'hA5;
`ifdef SQUARE_FP_REMAINDER_EN
      remainder = 9'h1FF;
`endif
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, c2;
    aclr_n   = 1'b0;
    in_valid = 1'b0;
    q        = 8'h00;
`ifdef SQUARE_FP_REMAINDER_EN
    remainder = 9'h000;
`endif
    #12;
    check_output("reset_radical", {16'd0, radical}, 32'd0);
    check_output("reset_valid", {31'd0, outData_valid}, 32'd0);
    @(posedge clk); #1;
    aclr_n = 1'b1;
    check_output("reset_ready", {31'd0, in_ready}, 32'd1);

    apply_stimulus(8'h10, 9'd0, 16'h0100, 1'b0, 1'b0, c1); wait_idle();
    apply_stimulus(8'hFF, 9'd0, 16'hFE01, 1'b0, 1'b0, c1); wait_idle();
    apply_stimulus(8'h00, 9'd0, 16'h0000, 1'b0, 1'b0, c1); wait_idle();
    check_output("radical_hold", {16'd0, radical}, 32'd0);

    // Back-to-back with in_valid held; q changes mid-RUN to the next operand.
    apply_stimulus(8'h03, 9'd0, 16'h0009, 1'b0, 1'b1, c1);
    q = 8'h05;
    apply_stimulus(8'h05, 9'd0, 16'h0019, 1'b0, 1'b0, c2);
    check_output("accept_spacing", c2 - c1, 32'd10);
    wait_idle();

    // Abort mid-RUN: no pulse may follow for the aborted operand.
    in_valid = 1'b1;
    q        = 8'h20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 aclr_n = 1'b0;
    #1;
    check_output("abort_radical", {16'd0, radical}, 32'd0);
    check_output("abort_valid", {31'd0, outData_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 aclr_n = 1'b1;
    check_output("abort_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check_output("abort_radical_after", {16'd0, radical}, 32'd0);
    apply_stimulus(8'h02, 9'd0, 16'h0004, 1'b0, 1'b0, c1); wait_idle();

`ifdef SQUARE_FP_REMAINDER_EN
    apply_stimulus(8'h03, 9'h005, 16'h000E, 1'b0, 1'b0, c1); wait_idle();
    apply_stimulus(8'h03, 9'h007, 16'h0010, 1'b1, 1'b0, c1); wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/square_fixed_point.md
SQUARE_FIXED_POINT -- requirements
Module: square_fixed_point

Interface
REQ-001 SHALL have parameter inputWidth, default 8: total width of the unsigned fixed-point root operand.
REQ-002 SHALL have parameter inputDecWidth, default 4: fractional bits of the root operand.
REQ-003 SHALL have port clk, input, 1: single clock, all state rising-edge triggered.
REQ-004 SHALL have port aclr_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand present on q.
REQ-006 SHALL have port in_ready, output, 1: block idle, operand accepted when in_valid & in_ready at a rising edge.
REQ-007 SHALL have port q, input, inputWidth: unsigned root operand.
REQ-008 SHALL have port radical, output, 2*inputWidth: reconstructed square, 2*inputDecWidth fractional bits.
REQ-009 SHALL have port outData_valid, output, 1: one-cycle pulse, radical holds a new result.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE; in_ready = (state==IDLE).
REQ-011 SHALL, on acceptance at edge A, capture q and clear the accumulator and bit counter, then enter RUN.
REQ-012 SHALL, in RUN, process one operand bit per edge using shift-add (accumulate a shifted copy of the captured q when the current bit is 1), LSB first.
REQ-013 SHALL enter DONE at edge A+inputWidth, with radical updated at that same edge to the exact product q*q (unsigned, no truncation, no rounding).
REQ-014 SHALL assert outData_valid exactly while state==DONE (one cycle), then return to IDLE at edge A+inputWidth+1.
REQ-015 SHALL accept the next operand no earlier than edge A+inputWidth+2; throughput is one result per inputWidth+2 cycles with in_valid held high.
REQ-016 SHALL ignore in_valid and q outside IDLE; changes to q after acceptance SHALL not affect the result.
REQ-017 SHALL hold radical stable from one completion until the next completion.
REQ-018 SHALL treat q=0 and q=all-ones as ordinary operands; result always fits 2*inputWidth bits without overflow.

Reset
REQ-019 SHALL, on aclr_n low, immediately force state=IDLE, counter=0, accumulator=0, radical=0, outData_valid=0; in_ready SHALL read 1 after reset is released.
REQ-020 SHALL abort any operation in progress when reset asserts mid-RUN or in DONE; no outData_valid pulse SHALL follow for that operand.

Configuration
REQ-021 SHALL compile in remainder support when macro SQUARE_FP_REMAINDER_EN is defined.
REQ-022 With SQUARE_FP_REMAINDER_EN: add input remainder (inputWidth+1 bits, captured at acceptance) and output rem_err (1 bit); radical = q*q + remainder, modulo 2^(2*inputWidth); rem_err = (remainder > 2*q), updated with radical, reset 0.
REQ-023 Without SQUARE_FP_REMAINDER_EN: ports remainder and rem_err SHALL not exist; radical = q*q; latency and handshake identical.

Verification
REQ-024 inputWidth=8, inputDecWidth=4: q=0x10 (1.0) accepted at edge A -> outData_valid high in cycle after edge A+8, radical=0x0100.
REQ-025 q=0xFF -> radical=0xFE01; q=0x00 -> radical=0x0000; each with one-cycle outData_valid pulse.
REQ-026 in_valid held high with q=0x03 then q=0x05 -> accepts spaced 10 cycles apart, radicals 0x0009 then 0x0019; q changed during RUN has no effect.
REQ-027 aclr_n pulsed low 3 cycles after acceptance of q=0x20 -> no outData_valid, radical=0, in_ready=1 after release; next q=0x02 -> radical=0x0004.
REQ-028 SQUARE_FP_REMAINDER_EN defined: q=0x03, remainder=0x05 -> radical=0x000E, rem_err=0; q=0x03, remainder=0x07 -> radical=0x0010, rem_err=1.
